scan_decoder: RTL
=================

Name:
scan_decoder

Overview:
Parametrised, registered one-hot decoder. Successor to the team's combinational 3-to-8 enable decoder. Two modes:
- Direct: a select value is captured on a load strobe and held.
- Scan: the active output walks 0..scan_lim with a programmable dwell per position, for row/digit strobing and channel sequencing.

All outputs are registered.

Parameters:
SEL_W, 3, select width; OUT_W = 2**SEL_W outputs (derived localparam, not overridable)
DWELL_W, 8, width of dwell count

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
en  input  1  global enable; low forces outputs off
mode  input  1  0 = direct, 1 = scan
load  input  1  capture sel (direct) / restart scan at sel (scan)
sel  input  SEL_W  select index
dwell  input  DWELL_W  cycles per scan position minus one
scan_lim  input  SEL_W  last index before wrap in scan mode
out  output  OUT_W  one-hot output, all-zero when inactive
idx  output  SEL_W  index currently driven on out
valid  output  1  out is driving a one-hot value
wrap  output  1  one-cycle pulse on scan wrap to index 0

Behaviour:
- Reset: rst_n sampled low at a clk edge gives state=IDLE, out=0, idx=0, valid=0, wrap=0, dwell counter cnt=0. Reset overrides all other inputs, including mid-scan.
- Invariant: out == (valid ? 1<<idx : 0). This holds every cycle; out is never multi-hot.
- States: IDLE, DIRECT, SCAN.
- en=0 (any state): next edge gives IDLE, out=0, valid=0, wrap=0, cnt=0. idx holds its value.
- IDLE transitions:
  - en & !mode & load: to DIRECT, idx<=sel.
  - en & mode: to SCAN, idx<=(load ? sel : 0), cnt<=0.
  - Otherwise stay in IDLE.
- DIRECT:
  - valid=1.
  - load: idx<=sel. Latency is 1 cycle from the load edge to out.
  - No load: hold.
  - mode=1: to SCAN, idx held, cnt<=0.
- SCAN:
  - valid=1. cnt increments each cycle.
  - When cnt==dwell: cnt<=0 and idx advances.
    - If idx>=scan_lim: idx<=0 and wrap=1 for exactly that one cycle.
    - Else: idx<=idx+1.
  - Each index is therefore displayed dwell+1 cycles. With dwell=0, idx advances every cycle.
  - load: idx<=sel, cnt<=0. load has priority over the advance; no wrap pulse.
  - mode=0: to DIRECT, idx frozen at its current value, cnt<=0. load on the same cycle applies sel.
- Boundary rules:
  - scan_lim=0: idx stays 0 and wrap pulses every dwell+1 cycles.
  - scan_lim lowered below idx mid-scan: the next advance wraps to 0 (>= compare).
  - sel>scan_lim loaded in SCAN: that index is shown for one dwell, then the scan wraps.
  - dwell and scan_lim are sampled live; a change takes effect on the next compare.
  - idx+1 never exceeds OUT_W-1 except via wrap. At scan_lim=OUT_W-1 the natural wrap gives 0.
- Arithmetic: idx, cnt and the compares are unsigned. cnt is DWELL_W bits wide and never exceeds dwell.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with en=1, mode=1 -> out=0, idx=0, valid=0, wrap=0. Release -> out=8'h01 one cycle later.
- Direct: en=1, mode=0, load pulse with sel=5 -> next cycle out=8'h20, valid=1. sel changed to 2 without load -> out stays 8'h20. Load with sel=7 -> out=8'h80.
- Scan: dwell=2, scan_lim=3 -> out sequence 01,01,01,02,02,02,04,04,04,08,08,08,01. wrap=1 only on the first 01 cycle after 08.
- Scan with dwell=0, scan_lim=7 -> out advances every cycle 01..80 then 01; wrap pulses once every 8 cycles.
- Mid-scan events:
  - With idx=6, scan_lim dropped to 4 -> next advance gives idx=0, wrap=1.
  - load sel=3 on an advance cycle -> idx=3, no wrap.
- Enable drop: en=0 mid-scan with idx=2 -> out=0, valid=0 next cycle. en=1 with mode=1, load=0 -> scan restarts at idx=0, out=8'h01.

Source files
------------

// File: rtl/scan_decoder_if.sv
// Bundled control inputs and registered one-hot outputs of the scan decoder.
// The master side drives mode/select/timing and observes out/idx/valid/wrap.
interface scan_decoder_if #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
);
  localparam int OUT_W = 2 ** SEL_W;

  logic               en;
  logic               mode;
  logic               load;
  logic [SEL_W-1:0]   sel;
  logic [DWELL_W-1:0] dwell;
  logic [SEL_W-1:0]   scan_lim;
  logic [OUT_W-1:0]   out;
  logic [SEL_W-1:0]   idx;
  logic               valid;
  logic               wrap;

  modport master (
    output en, mode, load, sel, dwell, scan_lim,
    input  out, idx, valid, wrap
  );

  modport slave (
    input  en, mode, load, sel, dwell, scan_lim,
    output out, idx, valid, wrap
  );
endinterface

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with a held direct-select mode and a scan mode
// that walks 0..scan_lim, spending dwell+1 cycles on each position.
//
//   state  | meaning
//   IDLE   | outputs off, idx retained
//   DIRECT | idx shows the last loaded sel
//   SCAN   | idx advances every dwell+1 cycles, wrapping after scan_lim
module scan_decoder #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  scan_decoder_if.slave  bus
);
  localparam int OUT_W = 2 ** SEL_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;

    if (!bus.en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.mode) begin
            state_d = SCAN;
            idx_d   = bus.load ? bus.sel : '0;
            cnt_d   = '0;
          end else if (bus.load) begin
            state_d = DIRECT;
            idx_d   = bus.sel;
            cnt_d   = '0;
          end
        end

        DIRECT: begin
          if (bus.load) idx_d = bus.sel;
          if (bus.mode) begin
            state_d = SCAN;
            cnt_d   = '0;
          end
        end

        SCAN: begin
          if (!bus.mode) begin
            state_d = DIRECT;
            cnt_d   = '0;
            if (bus.load) idx_d = bus.sel;
          end else if (bus.load) begin
            idx_d = bus.sel;
            cnt_d = '0;
          end else if (cnt_q >= bus.dwell) begin
            // >= keeps the counter bounded if dwell is lowered below cnt live
            cnt_d = '0;
            if (idx_q >= bus.scan_lim) begin
              idx_d  = '0;
              wrap_d = 1'b1;
            end else begin
              idx_d = idx_q + {{(SEL_W-1){1'b0}}, 1'b1};
            end
          end else begin
            cnt_d = cnt_q + {{(DWELL_W-1){1'b0}}, 1'b1};
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    valid_d = (state_d != IDLE);
    out_d   = '0;
    if (valid_d) out_d[idx_d] = 1'b1;
  end

  assign bus.out   = out_q;
  assign bus.idx   = idx_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;
endmodule
